// File: rtl/pattern_detector_pkg.sv
// Shared types and reset-time configuration for the serial pattern detector.
// The reset configuration makes the block look for the sequence 0-then-1.
package pattern_detector_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        FILLING  = 2'd1,
        ARMED    = 2'd2
    } state_e;

    localparam int   RST_PATTERN = 1;
    localparam int   RST_LEN     = 2;
    localparam logic RST_OVERLAP = 1'b1;

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector: configurable length/pattern, overlapping or
// non-overlapping matches, registered match pulse and saturating match count.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               A,
    input  logic               in_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               Y,
    output logic [CNT_W-1:0]   match_count
);

    logic [MAX_LEN-1:0] pattern_q,  pattern_d;
    logic [LEN_W-1:0]   len_q,      len_d;
    logic               overlap_q,  overlap_d;
    // The oldest history bit only ever falls off the end, so the stored part is
    // one bit short; together with the incoming bit it forms the full window.
    logic [MAX_LEN-2:0] history_q,  history_d;
    logic [LEN_W-1:0]   fill_q,     fill_d;
    state_e             state_q,    state_d;
    logic               match_q,    match_d;

    logic               accept;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] lenMask;
    logic [LEN_W-1:0]   fillInc;
    logic [LEN_W-1:0]   cfgLenClamped;
    logic               matchHit;

    assign accept        = in_valid & ~cfg_we;
    assign window        = {history_q, A};
    assign fillInc       = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    assign cfgLenClamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    always_comb begin
        lenMask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            lenMask[i] = (i < int'(len_q));
        end
    end

    assign matchHit = accept && (state_q != DISABLED) && (fillInc >= len_q) &&
                      ((window & lenMask) == (pattern_q & lenMask));

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        history_d = history_q;
        fill_d    = fill_q;
        state_d   = state_q;
        match_d   = 1'b0;

        if (cfg_we) begin
            pattern_d = cfg_pattern;
            len_d     = cfgLenClamped;
            overlap_d = cfg_overlap;
            history_d = '0;
            fill_d    = '0;
            state_d   = (cfgLenClamped == '0) ? DISABLED : FILLING;
        end else if (accept) begin
            history_d = window[MAX_LEN-2:0];
            match_d   = matchHit;
            fill_d    = (matchHit && !overlap_q) ? '0 : fillInc;
            case (state_q)
                DISABLED: state_d = DISABLED;
                FILLING,
                ARMED:    state_d = (fill_d >= len_q) ? ARMED : FILLING;
                default:  state_d = FILLING;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q <= MAX_LEN'(RST_PATTERN);
            len_q     <= LEN_W'(RST_LEN);
            overlap_q <= RST_OVERLAP;
            history_q <= '0;
            fill_q    <= '0;
            state_q   <= FILLING;
            match_q   <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
            match_q   <= match_d;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_count (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_count),
        .inc  (match_d),
        .count(match_count)
    );

    assign Y = match_q;

endmodule
